// File: rtl/ex_stage_ctrl_pkg.sv
// ex_stage_ctrl_pkg
//   Shared definitions for the EX stage control slice: FSM state encodings
//   and the pipeline control constants (reset level, flush level, TRUE/FALSE).
package ex_stage_ctrl_pkg;

   typedef enum logic [1:0] {
      EX_ST_IDLE     = 2'd0,
      EX_ST_MUL_WAIT = 2'd1,
      EX_ST_DIV_WAIT = 2'd2,
      EX_ST_DONE     = 2'd3
   } ex_state_e;

   // Reset is active-high; this is the level of rst_n that resets.
   localparam logic DFF_RST_ENABLE = 1'b1;
   localparam logic FLUSH          = 1'b1;
   localparam logic TRUE           = 1'b1;
   localparam logic FALSE          = 1'b0;

endpackage

// File: rtl/ex_stage_ctrl_if.sv
// ex_stage_ctrl_if
//   Handshake and control bundle between the ID/EX register, the EX stage
//   controller, the mul/div datapaths and the EX/MEM register.
//   slave  : the EX controller side (consumes pipeline inputs, drives status/pulses)
//   master : the surrounding pipeline side
//   Inputs to EX : pipe_flush, id_ex_valid, ex_is_mul_inst, ex_is_div_inst,
//                  ex_is_load, mem_allowin, div_done
//   Outputs of EX: ex_allowin, ex_valid, ex_mem_valid, mul_start, div_start,
//                  div_kill, ex_busy, ex_load_valid
interface ex_stage_ctrl_if;
   logic pipe_flush;
   logic id_ex_valid;
   logic ex_allowin;
   logic ex_is_mul_inst;
   logic ex_is_div_inst;
   logic ex_is_load;
   logic mem_allowin;
   logic div_done;
   logic ex_valid;
   logic ex_mem_valid;
   logic mul_start;
   logic div_start;
   logic div_kill;
   logic ex_busy;
   logic ex_load_valid;

   modport slave (
      input  pipe_flush, id_ex_valid, ex_is_mul_inst, ex_is_div_inst,
             ex_is_load, mem_allowin, div_done,
      output ex_allowin, ex_valid, ex_mem_valid, mul_start, div_start,
             div_kill, ex_busy, ex_load_valid
   );

   modport master (
      output pipe_flush, id_ex_valid, ex_is_mul_inst, ex_is_div_inst,
             ex_is_load, mem_allowin, div_done,
      input  ex_allowin, ex_valid, ex_mem_valid, mul_start, div_start,
             div_kill, ex_busy, ex_load_valid
   );
endinterface

// File: rtl/ex_stage_ctrl.sv
// ex_stage_ctrl
//   EX stage pipeline control: owns the EX valid bit, answers the ID->EX
//   valid/allowin handshake, sequences multi-cycle multiply (fixed latency
//   MUL_LAT) and divide (until div_done), and presents ex_mem_valid to MEM
//   under mem_allowin back-pressure.
//   Ports:
//     clk   - single clock
//     rst_n - synchronous reset, active-high despite the legacy name
//     ex    - ex_stage_ctrl_if.slave control bundle
//   Parameters:
//     MUL_LAT - multiplier latency in cycles (>= 2)
//     CNT_W   - width of the multiply wait counter (>= clog2(MUL_LAT))
module ex_stage_ctrl
   import ex_stage_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LAT = 2,
   parameter int unsigned CNT_W   = 4
) (
   input logic            clk,
   input logic            rst_n,
   ex_stage_ctrl_if.slave ex
);

   // MUL_WAIT spans MUL_LAT-1 cycles; cnt counts down to 0 inclusive.
   localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 2);

   ex_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ex_valid_q;
   logic             ex_ready_go;
   logic             allowin;
   logic             start_ok;
   logic             flushing;

   assign flushing = (ex.pipe_flush == FLUSH);

   // State register and counter
   always_ff @(posedge clk) begin
      if (rst_n == DFF_RST_ENABLE) begin
         state_q <= EX_ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // EX valid bit: flush beats a same-cycle accept
   always_ff @(posedge clk) begin
      if (rst_n == DFF_RST_ENABLE) begin
         ex_valid_q <= FALSE;
      end else if (flushing) begin
         ex_valid_q <= FALSE;
      end else if (allowin) begin
         ex_valid_q <= ex.id_ex_valid;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flushing) begin
         state_d = EX_ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            EX_ST_IDLE: begin
               if (ex_valid_q && ex.ex_is_mul_inst) begin
                  state_d = EX_ST_MUL_WAIT;
                  cnt_d   = MUL_CNT_INIT;
               end else if (ex_valid_q && ex.ex_is_div_inst) begin
                  state_d = EX_ST_DIV_WAIT;
               end
            end
            EX_ST_MUL_WAIT: begin
               if (cnt_q == '0) begin
                  state_d = EX_ST_DONE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            EX_ST_DIV_WAIT: begin
               if (ex.div_done == TRUE) begin
                  state_d = EX_ST_DONE;
               end
            end
            EX_ST_DONE: begin
               // Next instruction (if any) is latched at this edge and is
               // evaluated in IDLE during the following cycle.
               if (ex.mem_allowin) begin
                  state_d = EX_ST_IDLE;
               end
            end
            default: state_d = EX_ST_IDLE;
         endcase
      end
   end

   // Output logic
   always_comb begin
      ex_ready_go = ((state_q == EX_ST_IDLE) && !ex.ex_is_mul_inst && !ex.ex_is_div_inst)
                    || (state_q == EX_ST_DONE);
      allowin     = !ex_valid_q || (ex_ready_go && ex.mem_allowin);
      // Start pulses only from IDLE, so each fires once per instruction.
      start_ok    = (state_q == EX_ST_IDLE) && ex_valid_q && !flushing;

      ex.ex_allowin    = allowin;
      ex.ex_valid      = ex_valid_q;
      ex.ex_mem_valid  = ex_valid_q && ex_ready_go;
      ex.mul_start     = start_ok && ex.ex_is_mul_inst;
      ex.div_start     = start_ok && ex.ex_is_div_inst && !ex.ex_is_mul_inst;
      ex.div_kill      = flushing && (state_q == EX_ST_DIV_WAIT);
      ex.ex_busy       = (state_q == EX_ST_MUL_WAIT) || (state_q == EX_ST_DIV_WAIT);
      ex.ex_load_valid = ex_valid_q && ex.ex_is_load;
   end

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// tb_ex_stage_ctrl
//   Bench for ex_stage_ctrl. Holds an instruction-level model of EX (age of
//   the resident instruction, whether its divide result has arrived) and an
//   ID/EX register model that feeds the ex_is_* flags.
module tb_ex_stage_ctrl;

   localparam int MUL_LAT = 2;
   localparam int K_ALU = 0;
   localparam int K_MUL = 1;
   localparam int K_DIV = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic check_en = 1'b0;

   ex_stage_ctrl_if bus ();

   ex_stage_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst),
      .ex    (bus.slave)
   );

   always #5 clk = ~clk;

   // Instruction offered by ID
   int   id_kind = K_ALU;
   logic id_load = 1'b0;

   // Model of the instruction resident in EX
   logic m_valid = 1'b0;
   int   m_kind  = K_ALU;
   logic m_load  = 1'b0;
   int   m_age   = 0;
   logic m_seen  = 1'b0;

   assign bus.ex_is_mul_inst = (m_kind == K_MUL);
   assign bus.ex_is_div_inst = (m_kind == K_DIV);
   assign bus.ex_is_load     = m_load;

   logic e_ready, e_allowin, e_mul_start, e_div_start, e_kill, e_busy, e_load_valid;

   always_comb begin
      e_ready      = m_valid && ((m_kind == K_ALU) ||
                                 (m_kind == K_MUL && m_age >= MUL_LAT) ||
                                 (m_kind == K_DIV && m_seen));
      e_allowin    = !m_valid || (e_ready && bus.mem_allowin);
      e_mul_start  = m_valid && m_kind == K_MUL && m_age == 0 && !bus.pipe_flush;
      e_div_start  = m_valid && m_kind == K_DIV && m_age == 0 && !bus.pipe_flush;
      e_busy       = m_valid && ((m_kind == K_MUL && m_age >= 1 && m_age < MUL_LAT) ||
                                 (m_kind == K_DIV && m_age >= 1 && !m_seen));
      e_kill       = bus.pipe_flush && m_valid && m_kind == K_DIV && m_age >= 1 && !m_seen;
      e_load_valid = m_valid && m_load;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0; m_kind <= K_ALU; m_load <= 1'b0; m_age <= 0; m_seen <= 1'b0;
      end else if (bus.pipe_flush) begin
         m_valid <= 1'b0; m_age <= 0; m_seen <= 1'b0;
      end else if (e_allowin) begin
         m_valid <= bus.id_ex_valid; m_kind <= id_kind; m_load <= id_load;
         m_age <= 0; m_seen <= 1'b0;
      end else begin
         m_age <= m_age + 1;
         if (m_kind == K_DIV && m_age >= 1 && bus.div_done) m_seen <= 1'b1;
      end
   end

   task automatic cmp(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (check_en) begin
         cmp("m_ex_valid",      bus.ex_valid,      m_valid);
         cmp("m_ex_allowin",    bus.ex_allowin,    e_allowin);
         cmp("m_ex_mem_valid",  bus.ex_mem_valid,  e_ready);
         cmp("m_mul_start",     bus.mul_start,     e_mul_start);
         cmp("m_div_start",     bus.div_start,     e_div_start);
         cmp("m_div_kill",      bus.div_kill,      e_kill);
         cmp("m_ex_busy",       bus.ex_busy,       e_busy);
         cmp("m_ex_load_valid", bus.ex_load_valid, e_load_valid);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int kind);
      bus.id_ex_valid = 1'b1;
      id_kind = kind;
      id_load = 1'b0;
      tick();
      bus.id_ex_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      bus.pipe_flush  = 1'b0;
      bus.id_ex_valid = 1'b0;
      bus.mem_allowin = 1'b1;
      bus.div_done    = 1'b0;

      // Reset for two cycles
      tick();
      check_en = 1'b1;
      tick();
      #2;
      cmp("rst_ex_valid",  bus.ex_valid,     1'b0);
      cmp("rst_allowin",   bus.ex_allowin,   1'b1);
      cmp("rst_mul_start", bus.mul_start,    1'b0);
      cmp("rst_div_start", bus.div_start,    1'b0);
      cmp("rst_busy",      bus.ex_busy,      1'b0);
      cmp("rst_mem_valid", bus.ex_mem_valid, 1'b0);
      rst = 1'b0;
      tick();

      // Four back-to-back single-cycle ops, third one a load
      for (int i = 0; i < 6; i++) begin
         bus.id_ex_valid = (i < 4);
         id_kind = K_ALU;
         id_load = (i == 2);
         #2;
         cmp("alu_allowin",    bus.ex_allowin,    1'b1);
         cmp("alu_mem_valid",  bus.ex_mem_valid,  (i >= 1 && i <= 4));
         cmp("alu_load_valid", bus.ex_load_valid, (i == 3));
         tick();
      end

      // Multiply, no back-pressure
      issue(K_MUL);
      for (int c = 0; c < 4; c++) begin
         #2;
         cmp("mul_start",     bus.mul_start,    (c == 0));
         cmp("mul_allowin",   bus.ex_allowin,   (c >= 2));
         cmp("mul_mem_valid", bus.ex_mem_valid, (c == 2));
         cmp("mul_busy",      bus.ex_busy,      (c == 1));
         tick();
      end

      // Divide, div_done in cycle 33
      issue(K_DIV);
      for (int c = 0; c < 36; c++) begin
         bus.div_done = (c == 33);
         #2;
         cmp("div_start",     bus.div_start,    (c == 0));
         cmp("div_mem_valid", bus.ex_mem_valid, (c == 34));
         cmp("div_busy",      bus.ex_busy,      (c >= 1 && c <= 33));
         cmp("div_allowin",   bus.ex_allowin,   (c >= 34));
         tick();
      end
      bus.div_done = 1'b0;

      // Multiply with MEM stalled in cycles 2-4, ALU op waiting in ID
      issue(K_MUL);
      for (int c = 0; c < 7; c++) begin
         bus.mem_allowin = !(c >= 2 && c <= 4);
         bus.id_ex_valid = (c >= 2 && c <= 5);
         id_kind = K_ALU;
         #2;
         cmp("bp_mul_start", bus.mul_start,    (c == 0));
         cmp("bp_mem_valid", bus.ex_mem_valid, (c >= 2));
         cmp("bp_allowin",   bus.ex_allowin,   (c >= 5));
         cmp("bp_ex_valid",  bus.ex_valid,     1'b1);
         tick();
      end
      bus.id_ex_valid = 1'b0;
      bus.mem_allowin = 1'b1;
      tick();

      // Divide flushed in cycle 10; a stray div_done in cycle 33
      issue(K_DIV);
      for (int c = 0; c < 36; c++) begin
         bus.pipe_flush = (c == 10);
         bus.div_done   = (c == 33);
         #2;
         cmp("fl_div_kill",  bus.div_kill,     (c == 10));
         cmp("fl_ex_valid",  bus.ex_valid,     (c <= 10));
         cmp("fl_mem_valid", bus.ex_mem_valid, 1'b0);
         cmp("fl_busy",      bus.ex_busy,      (c >= 1 && c <= 10));
         tick();
      end
      bus.pipe_flush = 1'b0;
      bus.div_done   = 1'b0;

      // Flush and accept in the same cycle
      bus.id_ex_valid = 1'b1;
      id_kind = K_ALU;
      bus.pipe_flush = 1'b1;
      #2;
      cmp("fa_allowin", bus.ex_allowin, 1'b1);
      tick();
      bus.id_ex_valid = 1'b0;
      bus.pipe_flush = 1'b0;
      #2;
      cmp("fa_ex_valid",  bus.ex_valid,     1'b0);
      cmp("fa_mem_valid", bus.ex_mem_valid, 1'b0);
      tick();

      // div_done in cycle 0 is ignored; in cycle 1 it completes the divide
      issue(K_DIV);
      for (int c = 0; c < 4; c++) begin
         bus.div_done = (c <= 1);
         #2;
         cmp("d1_mem_valid", bus.ex_mem_valid, (c == 2));
         cmp("d1_busy",      bus.ex_busy,      (c == 1));
         cmp("d1_ex_valid",  bus.ex_valid,     (c <= 2));
         tick();
      end
      bus.div_done = 1'b0;

      // Reset in the middle of a divide
      issue(K_DIV);
      tick();
      rst = 1'b1;
      tick();
      #2;
      cmp("mr_ex_valid", bus.ex_valid,   1'b0);
      cmp("mr_busy",     bus.ex_busy,    1'b0);
      cmp("mr_allowin",  bus.ex_allowin, 1'b1);
      cmp("mr_kill",     bus.div_kill,   1'b0);
      rst = 1'b0;
      tick();
      tick();

      check_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
